// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The write request type is what the long-unit result FIFO stores.
package regfile_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of pipeline, long-unit, decode and regfile-port signals around the arbiter.
// Handshakes: a transfer happens on a rising edge where both valid (lu_issue / lu_wb_valid) and ready are high; ready never depends on valid.
interface regfile_wb_arbiter_if #(parameter int QDEPTH = 2);
    import regfile_pkg::*;
    localparam int OUT_W = $clog2(QDEPTH + 1);

    logic              pipe_wr_en;
    logic [ADDR_W-1:0] pipe_wr_addr;
    logic [DATA_W-1:0] pipe_wr_data;
    logic              lu_issue;
    logic [ADDR_W-1:0] lu_issue_addr;
    logic              lu_issue_ready;
    logic              lu_wb_valid;
    logic [ADDR_W-1:0] lu_wb_addr;
    logic [DATA_W-1:0] lu_wb_data;
    logic              lu_wb_ready;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic [ADDR_W-1:0] id_rd;
    logic              id_rd_en;
    logic              stall;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [OUT_W-1:0]  outstanding;
    logic              err;

    modport slave (
        input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        input  lu_issue, lu_issue_addr, lu_wb_valid, lu_wb_addr, lu_wb_data,
        input  id_rs1, id_rs2, id_rd, id_rd_en,
        output lu_issue_ready, lu_wb_ready, stall,
        output RegWrite, WriteRegister, WriteData, outstanding, err
    );

    modport master (
        output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        output lu_issue, lu_issue_addr, lu_wb_valid, lu_wb_addr, lu_wb_data,
        output id_rs1, id_rs2, id_rd, id_rd_en,
        input  lu_issue_ready, lu_wb_ready, stall,
        input  RegWrite, WriteRegister, WriteData, outstanding, err
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small circular FIFO holding long-unit results until the regfile port is free.
// Push while full and pop while empty are ignored.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    wb_req_t          mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(QDEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: pipeline writeback wins, buffered long-unit results fill idle cycles.
// Tracks registers owed a long-unit result and stalls decode on hazards against them.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int OUT_W = $clog2(QDEPTH + 1);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [OUT_W-1:0]    outstanding_q;
    logic                err_q;
    logic                err_evt;
    logic                issue_acc;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    wb_req_t             head;
    wb_req_t             push_req;

    assign bus.lu_issue_ready = (outstanding_q < OUT_W'(QDEPTH)) && !pending[bus.lu_issue_addr];
    assign bus.lu_wb_ready    = !full;
    assign bus.outstanding    = outstanding_q;
    assign bus.err            = err_q;

    assign issue_acc = bus.lu_issue && bus.lu_issue_ready;
    assign push      = bus.lu_wb_valid && !full;
    assign pop       = reset && !bus.pipe_wr_en && !empty;
    assign push_req  = '{addr: bus.lu_wb_addr, data: bus.lu_wb_data};

    wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        if (reset) begin
            if (bus.pipe_wr_en) begin
                bus.RegWrite      = 1'b1;
                bus.WriteRegister = bus.pipe_wr_addr;
                bus.WriteData     = bus.pipe_wr_data;
            end else if (!empty) begin
                bus.RegWrite      = 1'b1;
                bus.WriteRegister = head.addr;
                bus.WriteData     = head.data;
            end
        end
    end

    // pending[ZERO_REG] is never set, so the explicit checks only guard the index
    assign bus.stall = (pending[bus.id_rs1] && bus.id_rs1 != ZERO_REG) ||
                       (pending[bus.id_rs2] && bus.id_rs2 != ZERO_REG) ||
                       (bus.id_rd_en && pending[bus.id_rd] && bus.id_rd != ZERO_REG);

    assign err_evt = (push && !pending[bus.lu_wb_addr] && bus.lu_wb_addr != ZERO_REG) ||
                     (bus.pipe_wr_en && pending[bus.pipe_wr_addr]);

    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head.addr] = 1'b0;
        if (issue_acc && bus.lu_issue_addr != ZERO_REG) pending_nxt[bus.lu_issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending       <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (err_evt) err_q <= 1'b1;
            // a stray (error) result popped with nothing outstanding must not wrap the count
            if (issue_acc && !pop)
                outstanding_q <= outstanding_q + OUT_W'(1);
            else if (!issue_acc && pop && outstanding_q != '0)
                outstanding_q <= outstanding_q - OUT_W'(1);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int QDEPTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.QDEPTH(QDEPTH)) bus ();

    regfile_wb_arbiter #(.QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0]        inflight[$];
    bit                       m_pend[NUM_REGS];
    int                       m_outst;
    bit                       m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hz(input logic [ADDR_W-1:0] a);
        return m_pend[a] && (a != ZERO_REG);
    endfunction

    function automatic bit exp_issue_ready();
        return (m_outst < QDEPTH) && !m_pend[bus.lu_issue_addr];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        inflight.delete();
        for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
        m_outst = 0;
        m_err   = 1'b0;
    endtask

    task automatic check_outputs();
        bit e_rw;
        logic [ADDR_W+DATA_W-1:0] hd;
        e_rw = reset && (bus.pipe_wr_en || exp_q.size() != 0);
        check("lu_issue_ready", bus.lu_issue_ready, exp_issue_ready());
        check("lu_wb_ready", bus.lu_wb_ready, exp_q.size() < QDEPTH);
        check("RegWrite", bus.RegWrite, e_rw);
        if (e_rw) begin
            if (bus.pipe_wr_en) begin
                check("WriteRegister", bus.WriteRegister, bus.pipe_wr_addr);
                check("WriteData", bus.WriteData, bus.pipe_wr_data);
            end else begin
                hd = exp_q[0];
                check("WriteRegister", bus.WriteRegister, hd[ADDR_W+DATA_W-1:DATA_W]);
                check("WriteData", bus.WriteData, hd[DATA_W-1:0]);
            end
        end
        check("stall", bus.stall, hz(bus.id_rs1) || hz(bus.id_rs2) || (bus.id_rd_en && hz(bus.id_rd)));
        check("outstanding", bus.outstanding, m_outst);
        check("err", bus.err, m_err);
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic step();
        bit issue_acc, push, pop;
        logic [ADDR_W+DATA_W-1:0] hd;
        #1;
        check_outputs();
        issue_acc = reset && bus.lu_issue && exp_issue_ready();
        push      = reset && bus.lu_wb_valid && (exp_q.size() < QDEPTH);
        pop       = reset && !bus.pipe_wr_en && (exp_q.size() != 0);
        if (reset) begin
            if (push && !m_pend[bus.lu_wb_addr] && bus.lu_wb_addr != ZERO_REG) m_err = 1'b1;
            if (bus.pipe_wr_en && m_pend[bus.pipe_wr_addr]) m_err = 1'b1;
            if (pop) begin
                hd = exp_q.pop_front();
                m_pend[hd[ADDR_W+DATA_W-1:DATA_W]] = 1'b0;
            end
            if (issue_acc) begin
                if (bus.lu_issue_addr != ZERO_REG) m_pend[bus.lu_issue_addr] = 1'b1;
                inflight.push_back(bus.lu_issue_addr);
            end
            m_outst = m_outst + (issue_acc ? 1 : 0);
            if (pop && m_outst > 0) m_outst--;
            if (push) begin
                exp_q.push_back({bus.lu_wb_addr, bus.lu_wb_data});
                if (inflight.size() != 0) void'(inflight.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_wr_en    = 1'b0;
        bus.pipe_wr_addr  = '0;
        bus.pipe_wr_data  = '0;
        bus.lu_issue      = 1'b0;
        bus.lu_issue_addr = '0;
        bus.lu_wb_valid   = 1'b0;
        bus.lu_wb_addr    = '0;
        bus.lu_wb_data    = '0;
        bus.id_rs1        = ZERO_REG;
        bus.id_rs2        = ZERO_REG;
        bus.id_rd         = ZERO_REG;
        bus.id_rd_en      = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < n; i++) step();
        reset = 1'b1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        bus.lu_issue = 1'b1; bus.lu_issue_addr = a;
    endtask

    task automatic result(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.lu_wb_valid = 1'b1; bus.lu_wb_addr = a; bus.lu_wb_data = d;
    endtask

    task automatic pipe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.pipe_wr_en = 1'b1; bus.pipe_wr_addr = a; bus.pipe_wr_data = d;
    endtask

    initial begin
        idle();
        model_clear();
        #1;
        check("reset_RegWrite", bus.RegWrite, 1'b0);
        check("reset_lu_wb_ready", bus.lu_wb_ready, 1'b1);
        check("reset_outstanding", bus.outstanding, 0);
        check("reset_err", bus.err, 1'b0);
        @(posedge clk); #1;
        pipe(5'd4, 64'h1);
        step();
        idle();
        reset = 1'b1;
        step();

        // reset in the middle of an op
        issue(5'd5); step(); idle();
        result(5'd5, 64'h55); step(); idle();
        bus.id_rs1 = 5'd5;
        reset = 1'b0;
        model_clear();
        #1;
        check("midrst_outstanding", bus.outstanding, 0);
        check("midrst_stall", bus.stall, 1'b0);
        check("midrst_RegWrite", bus.RegWrite, 1'b0);
        step();
        reset = 1'b1;
        #1;
        check("midrst_fifo_empty", bus.RegWrite, 1'b0);
        step(); idle();

        // basic flow
        issue(5'd3); step(); idle();
        step();
        result(5'd3, 64'hDEAD_BEEF); step(); idle();
        #1;
        check("basic_RegWrite", bus.RegWrite, 1'b1);
        check("basic_WriteRegister", bus.WriteRegister, 5'd3);
        check("basic_WriteData", bus.WriteData, 64'hDEAD_BEEF);
        step();
        bus.id_rs1 = 5'd3;
        #1;
        check("basic_outstanding", bus.outstanding, 0);
        check("basic_pending_clear", bus.stall, 1'b0);
        step(); idle();

        // pipeline priority over the FIFO head
        issue(5'd7); step(); idle();
        result(5'd7, 64'h11); step(); idle();
        for (int i = 0; i < 3; i++) begin
            pipe(5'd2, 64'h22);
            #1;
            check("prio_pipe_addr", bus.WriteRegister, 5'd2);
            step();
        end
        idle();
        #1;
        check("prio_head_addr", bus.WriteRegister, 5'd7);
        check("prio_head_data", bus.WriteData, 64'h11);
        step();

        // hazard stall
        issue(5'd9); step(); idle();
        bus.id_rs2 = 5'd9;
        #1;
        check("stall_rs2", bus.stall, 1'b1);
        bus.id_rs1 = 5'd31; bus.id_rs2 = 5'd0;
        #1;
        check("stall_x31", bus.stall, 1'b0);
        bus.id_rs2 = 5'd9;
        step();
        result(5'd9, 64'h99); step(); bus.lu_wb_valid = 1'b0;
        #1;
        check("stall_during_write", bus.stall, 1'b1);
        step();
        check("stall_released", bus.stall, 1'b0);
        idle(); step();

        // backpressure
        issue(5'd1); step();
        issue(5'd2); step();
        issue(5'd4);
        #1;
        check("bp_issue_refused", bus.lu_issue_ready, 1'b0);
        step();
        bus.lu_issue = 1'b0;
        pipe(5'd10, 64'hA);
        result(5'd1, 64'h101); step();
        result(5'd2, 64'h202); step();
        bus.lu_wb_valid = 1'b0;
        #1;
        check("bp_wb_ready_low", bus.lu_wb_ready, 1'b0);
        step();
        bus.pipe_wr_en = 1'b0;
        issue(5'd4);
        #1;
        check("bp_first_X1", bus.WriteRegister, 5'd1);
        check("bp_issue_still_refused", bus.lu_issue_ready, 1'b0);
        step();
        check("bp_second_X2", bus.WriteRegister, 5'd2);
        check("bp_issue_accepted", bus.lu_issue_ready, 1'b1);
        step(); idle();
        result(5'd4, 64'h404); step(); idle();
        step(); step();

        // protocol error is sticky
        result(5'd12, 64'hC); step(); idle();
        #1;
        check("err_set", bus.err, 1'b1);
        for (int i = 0; i < 4; i++) step();
        check("err_sticky", bus.err, 1'b1);
        do_reset(2);
        #1;
        check("err_cleared", bus.err, 1'b0);
        step();

        // random traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [ADDR_W-1:0] a;
            idle();
            if ($urandom_range(0, 99) < 30) begin
                a = 5'($urandom_range(0, 31));
                if (m_pend[a]) a = ZERO_REG;
                pipe(a, {$urandom, $urandom});
            end
            if ($urandom_range(0, 99) < 40)
                issue(($urandom_range(0, 9) == 0) ? ZERO_REG : 5'($urandom_range(0, 7)));
            if (inflight.size() != 0 && $urandom_range(0, 99) < 50)
                result(inflight[0], {$urandom, $urandom});
            bus.id_rs1   = ($urandom_range(0, 7) == 0) ? ZERO_REG : 5'($urandom_range(0, 7));
            bus.id_rs2   = 5'($urandom_range(0, 7));
            bus.id_rd    = 5'($urandom_range(0, 7));
            bus.id_rd_en = 1'($urandom_range(0, 1));
            if (cyc % 400 == 399) do_reset(2);
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Controls the single write port of the 32x64 register file (X31 hard-wired to zero).
- Two writers share the port: the main pipeline writeback, which has priority, and a long-latency unit (multiplier/divider) whose results are buffered in a small FIFO.
- Keeps a per-register pending scoreboard and raises a stall to decode on RAW/WAW hazards against in-flight long-latency results.

Parameters:
- DATA_W, 64, register data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, architectural registers; index NUM_REGS-1 is the zero register
- QDEPTH, 2, long-unit result FIFO depth; also the maximum number of outstanding long-unit ops

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pipe_wr_en  in  1  pipeline WB write request; always accepted
- pipe_wr_addr  in  ADDR_W  pipeline WB destination
- pipe_wr_data  in  DATA_W  pipeline WB data
- lu_issue  in  1  long unit issues an op
- lu_issue_addr  in  ADDR_W  destination of the issued op
- lu_issue_ready  out  1  issue accepted this cycle when high
- lu_wb_valid  in  1  long-unit result valid
- lu_wb_addr  in  ADDR_W  result destination
- lu_wb_data  in  DATA_W  result data
- lu_wb_ready  out  1  FIFO can accept a result
- id_rs1, id_rs2  in  ADDR_W  decode-stage source registers
- id_rd  in  ADDR_W  decode-stage destination
- id_rd_en  in  1  decode instruction writes id_rd
- stall  out  1  decode must hold
- RegWrite  out  1  regfile write enable
- WriteRegister  out  ADDR_W  regfile write address
- WriteData  out  DATA_W  regfile write data
- outstanding  out  $clog2(QDEPTH+1)  issued but not yet written long-unit ops
- err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, async): pending[] all 0, FIFO empty, outstanding=0, err=0. Outputs during reset: RegWrite=0, lu_wb_ready=1, stall=0. In-flight results are discarded.
- Issue accept: lu_issue && lu_issue_ready.
  - lu_issue_ready = (outstanding<QDEPTH) && !pending[lu_issue_addr]; computed from registered state only.
  - Accept increments outstanding and sets pending[addr] at the next edge. Issue to X31 is accepted but never sets pending.
- Result push: lu_wb_valid && lu_wb_ready, where lu_wb_ready = !fifo_full (registered).
  - Push stores {addr,data}. No bypass: the earliest port write is the cycle after the push.
- Port arbitration (combinational, per cycle):
  - If pipe_wr_en: RegWrite=1 with pipe_wr_addr/data. The FIFO head waits.
  - Else if FIFO non-empty: RegWrite=1 with head addr/data. Pop at the edge; outstanding decrements; pending[head addr] clears.
  - Else: RegWrite=0.
- Simultaneous events:
  - Issue and pop in the same cycle leaves outstanding unchanged.
  - A pop clearing r while lu_issue_addr==r is still refused that cycle, because pending was still set.
  - Push and pop in the same cycle are both performed, including when the FIFO is full at the start of the cycle only if lu_wb_ready was high; lu_wb_ready is registered, so a full FIFO refuses the push.
- FIFO pointers wrap modulo QDEPTH.
- stall (combinational) = any of:
  - (pending[id_rs1] && id_rs1!=31)
  - pending[id_rs2]
  - (id_rd_en && pending[id_rd])
  - Zero register never stalls.
- err set (sticky until reset) on any of:
  - a push whose addr is not pending (X31 excepted)
  - pipe_wr_en to a pending register
  - issue while outstanding==QDEPTH with lu_issue high and ignored is NOT an error
- Writes to X31 pass to the port unchanged; the regfile discards them.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W, ADDR_W, NUM_REGS
  - ZERO_REG=5'd31
  - typedef wb_req_t {addr, data}
- One natural sub-module: wb_fifo, a parameterised QDEPTH-entry synchronous FIFO of wb_req_t with full/empty, async active-low reset.
- Scoreboard, counter and arbitration mux live in the top module.

Test Plan:
- Reset mid-op: issue to X5, push its result, assert reset=0 before the pop -> outstanding=0, pending clear, RegWrite=0, FIFO empty after release.
- Basic flow: issue X3, result 64'hDEAD_BEEF pushed at cycle 4, pipe idle -> RegWrite=1, WriteRegister=3, WriteData=DEAD_BEEF at cycle 5; outstanding back to 0; pending[3]=0 at cycle 6.
- Priority: FIFO head X7=64'h11 while pipe writes X2=64'h22 for 3 cycles -> port carries X2 for 3 cycles; X7 written on the 4th cycle.
- Hazard stall: pending[9] set, id_rs2=9 -> stall=1 until the cycle after X9 is written; id_rs1=31 with anything pending -> stall=0.
- Backpressure: QDEPTH=2, two issues (X1, X2) -> third issue to X4 sees lu_issue_ready=0. Two pushes while pipe_wr_en held high -> lu_wb_ready=0. Release the pipe -> X1 then X2 written in order, third issue then accepted.
- Error: push to X12 with nothing pending -> err=1 next cycle, stays 1 until reset.
